handshake_slice_chain: RTL and testbench

//  Parametrised valid/ready register slice; successor to the single backward-registered slice.

---
 rtl/handshake_slice_chain_pkg.sv | 33 +++
 rtl/handshake_slice_chain_stage.sv | 113 +++++++++++
 rtl/handshake_slice_chain.sv | 99 +++++++++
 tb/tb_handshake_slice_chain.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_slice_chain_pkg.sv
// Shared constants and elaboration helpers for the valid/ready slice chain.
// Mode encodings select how each stage registers its handshake.
package hs_pkg;

  localparam int HS_MODE_BYPASS = 0;
  localparam int HS_MODE_FWD    = 1;
  localparam int HS_MODE_BWD    = 2;
  localparam int HS_MODE_FULL   = 3;

  localparam int HS_MAX_STAGES  = 8;

  // Cycles from a src transfer to the matching dst_vaild for a whole chain.
  function automatic int hs_latency(input int mode, input int stages);
    case (mode)
      HS_MODE_FWD, HS_MODE_FULL: return stages;
      default:                   return 0;
    endcase
  endfunction

  // Occupancy counter width: enough for 2 beats per stage plus zero.
  function automatic int hs_occ_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  function automatic int hs_max_beats(input int mode, input int stages);
    case (mode)
      HS_MODE_FWD, HS_MODE_BWD: return stages;
      HS_MODE_FULL:             return 2 * stages;
      default:                  return 0;
    endcase
  endfunction

endpackage

// File: rtl/handshake_slice_chain_stage.sv
// One valid/ready register slice; MODE picks bypass, forward, backward (skid)
// or skid-plus-output registration.
module handshake_slice_stage
  import hs_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int MODE  = HS_MODE_BWD
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             src_vaild,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             dst_vaild,
  output logic [WIDTH-1:0] dst_data,
  input  logic             dst_ready
);

  if (MODE == HS_MODE_BYPASS) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ s_rst;
    assign dst_vaild     = src_vaild;
    assign dst_data      = src_data;
    assign src_ready     = dst_ready;

  end else if (MODE == HS_MODE_FWD) begin : g_fwd
    logic             out_vld_reg;
    logic [WIDTH-1:0] out_data_reg;

    assign src_ready = ~out_vld_reg | dst_ready;
    assign dst_vaild = out_vld_reg;
    assign dst_data  = out_data_reg;

    always_ff @(posedge clk) begin
      if (s_rst) begin
        out_vld_reg <= 1'b0;
      end else if (src_ready) begin
        out_vld_reg <= src_vaild;
        if (src_vaild) begin
          out_data_reg <= src_data;
        end
      end
    end

  end else if (MODE == HS_MODE_BWD) begin : g_bwd
    logic             skid_vld_reg;
    logic             ready_reg;
    logic [WIDTH-1:0] skid_data_reg;

    // ready_reg always mirrors ~skid_vld_reg but comes straight from a flop.
    assign src_ready = ready_reg;
    assign dst_vaild = src_vaild | skid_vld_reg;
    assign dst_data  = skid_vld_reg ? skid_data_reg : src_data;

    always_ff @(posedge clk) begin
      if (s_rst) begin
        skid_vld_reg <= 1'b0;
        ready_reg    <= 1'b1;
      end else if (dst_ready) begin
        skid_vld_reg <= 1'b0;
        ready_reg    <= 1'b1;
      end else if (src_vaild && ready_reg) begin
        skid_vld_reg  <= 1'b1;
        ready_reg     <= 1'b0;
        skid_data_reg <= src_data;
      end
    end

  end else begin : g_full
    logic             skid_vld_reg;
    logic             ready_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             out_vld_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             mid_vld;
    logic [WIDTH-1:0] mid_data;
    logic             mid_ready;

    // The skid half faces upstream, the output register faces downstream.
    assign mid_vld   = src_vaild | skid_vld_reg;
    assign mid_data  = skid_vld_reg ? skid_data_reg : src_data;
    assign mid_ready = ~out_vld_reg | dst_ready;

    assign src_ready = ready_reg;
    assign dst_vaild = out_vld_reg;
    assign dst_data  = out_data_reg;

    always_ff @(posedge clk) begin
      if (s_rst) begin
        skid_vld_reg <= 1'b0;
        ready_reg    <= 1'b1;
        out_vld_reg  <= 1'b0;
      end else begin
        if (mid_ready) begin
          skid_vld_reg <= 1'b0;
          ready_reg    <= 1'b1;
        end else if (src_vaild && ready_reg) begin
          skid_vld_reg  <= 1'b1;
          ready_reg     <= 1'b0;
          skid_data_reg <= src_data;
        end

        if (mid_ready) begin
          out_vld_reg <= mid_vld;
          if (mid_vld) begin
            out_data_reg <= mid_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/handshake_slice_chain.sv
// Cascade of STAGES identical valid/ready slices with a beat occupancy counter.
// Handshake outputs are forced quiet while s_rst is high.
module handshake_slice_chain
  import hs_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int MODE   = HS_MODE_BWD,
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         s_rst,
  input  logic                         src_vaild,
  input  logic [WIDTH-1:0]             src_data,
  output logic                         src_ready,
  output logic                         dst_vaild,
  output logic [WIDTH-1:0]             dst_data,
  input  logic                         dst_ready,
  output logic                         idle,
  output logic [hs_occ_w(STAGES)-1:0]  occupancy
);

  localparam int OCC_W = hs_occ_w(STAGES);

  if (MODE < HS_MODE_BYPASS || MODE > HS_MODE_FULL) begin : g_bad_mode
    $error("handshake_slice_chain: MODE must be 0..3");
  end
  if (STAGES < 1 || STAGES > HS_MAX_STAGES) begin : g_bad_stages
    $error("handshake_slice_chain: STAGES must be 1..8");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("handshake_slice_chain: WIDTH must be at least 1");
  end

  logic [STAGES:0]  chain_vld;
  logic [STAGES:0]  chain_ready;
  logic [WIDTH-1:0] chain_data [0:STAGES];

  assign chain_vld[0]       = src_vaild;
  assign chain_data[0]      = src_data;
  assign chain_ready[STAGES] = dst_ready;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    handshake_slice_stage #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_stage (
      .clk       (clk),
      .s_rst     (s_rst),
      .src_vaild (chain_vld[gi]),
      .src_data  (chain_data[gi]),
      .src_ready (chain_ready[gi]),
      .dst_vaild (chain_vld[gi+1]),
      .dst_data  (chain_data[gi+1]),
      .dst_ready (chain_ready[gi+1])
    );
  end

  // Gating keeps the combinational bypass/skid paths silent during reset too.
  assign src_ready = chain_ready[0] & ~s_rst;
  assign dst_vaild = chain_vld[STAGES] & ~s_rst;
  assign dst_data  = chain_data[STAGES];

  if (MODE == HS_MODE_BYPASS) begin : g_no_count
    assign occupancy = '0;
  end else begin : g_count
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic             src_xfer;
    logic             dst_xfer;

    assign src_xfer = src_vaild & src_ready;
    assign dst_xfer = dst_vaild & dst_ready;

    always_comb begin
      occ_next = occ_reg;
      if (src_xfer && !dst_xfer) begin
        occ_next = occ_reg + OCC_ONE;
      end else if (dst_xfer && !src_xfer) begin
        occ_next = occ_reg - OCC_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (s_rst) begin
        occ_reg <= '0;
      end else begin
        occ_reg <= occ_next;
      end
    end

    assign occupancy = s_rst ? '0 : occ_reg;
  end

  assign idle = (occupancy == '0);

endmodule

// File: tb/tb_handshake_slice_chain.sv
// Directed and randomised checks of handshake_slice_chain over five
// MODE/STAGES configurations sharing one clock and reset.
module tb_handshake_slice_chain;
  import hs_pkg::*;

  localparam int N = 5;
  localparam int W = 9;

  logic clk = 1'b0;
  logic s_rst;
  logic [N-1:0] src_vaild;
  logic [N-1:0] src_ready;
  logic [N-1:0] dst_vaild;
  logic [N-1:0] dst_ready;
  logic [N-1:0] idle;
  logic [W-1:0] src_data [N];
  logic [W-1:0] dst_data [N];
  logic [3:0]   occ      [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state for the soak.
  logic [W-1:0] sb_mem [N][16];
  int           wr_p [N];
  int           rd_p [N];
  int           seq  [N];
  logic         took [N];
  logic         stall [N];
  logic [W-1:0] stall_data [N];

  always #5 clk = ~clk;

  // dut0: MODE0 S1, dut1: MODE1 S4, dut2: MODE2 S1, dut3: MODE3 S1, dut4: MODE3 S2
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_dut
    localparam int M = (gi < 4) ? gi : 3;
    localparam int S = (gi == 1) ? 4 : ((gi == 4) ? 2 : 1);
    logic [hs_occ_w(S)-1:0] occ_w;

    handshake_slice_chain #(
      .WIDTH  (W),
      .MODE   (M),
      .STAGES (S)
    ) u_dut (
      .clk       (clk),
      .s_rst     (s_rst),
      .src_vaild (src_vaild[gi]),
      .src_data  (src_data[gi]),
      .src_ready (src_ready[gi]),
      .dst_vaild (dst_vaild[gi]),
      .dst_data  (dst_data[gi]),
      .dst_ready (dst_ready[gi]),
      .idle      (idle[gi]),
      .occupancy (occ_w)
    );
    assign occ[gi] = 4'(occ_w);
  end

  task automatic idle_inputs();
    src_vaild = '0;
    dst_ready = '0;
    for (int i = 0; i < N; i++) src_data[i] = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_rst = 1'b1;
    @(negedge clk);
    src_vaild = '1;
    @(negedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      n_checks++;
      if ({src_ready[g], dst_vaild[g], idle[g], occ[g]} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: src_ready=%b dst_vaild=%b idle=%b occ=%0d, expected 0 0 1 0",
                 g, src_ready[g], dst_vaild[g], idle[g], occ[g]);
      end
    end
    @(negedge clk);
    s_rst = 1'b0;
    src_vaild = '0;
    #1;
    for (int g = 0; g < N; g++) begin
      n_checks++;
      if ({src_ready[g], dst_vaild[g], idle[g], occ[g]} !== {(g != 0), 1'b0, 1'b1, 4'd0}) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: src_ready=%b dst_vaild=%b idle=%b occ=%0d, expected %b 0 1 0",
                 g, src_ready[g], dst_vaild[g], idle[g], occ[g], (g != 0));
      end
    end
  endtask

  task automatic test_mid_reset();
    dst_ready[3] = 1'b0;
    @(negedge clk); src_vaild[3] = 1'b1; src_data[3] = 9'h011;
    @(negedge clk); src_data[3] = 9'h022;
    @(negedge clk); src_vaild[3] = 1'b0;
    #1;
    n_checks++;
    if ({occ[3], dst_vaild[3], dst_data[3], src_ready[3]} !== {4'd2, 1'b1, 9'h011, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_full: occ=%0d dst_vaild=%b dst_data=%h src_ready=%b, expected 2 1 011 0",
               occ[3], dst_vaild[3], dst_data[3], src_ready[3]);
    end
    @(negedge clk); s_rst = 1'b1;
    @(negedge clk); s_rst = 1'b0;
    #1;
    n_checks++;
    if ({dst_vaild[3], occ[3], idle[3], src_ready[3]} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_after: dst_vaild=%b occ=%0d idle=%b src_ready=%b, expected 0 0 1 1",
               dst_vaild[3], occ[3], idle[3], src_ready[3]);
    end
    dst_ready[3] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (dst_vaild[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_discard: dst_vaild=%b, expected 0", dst_vaild[3]);
    end
    dst_ready[3] = 1'b0;
  endtask

  task automatic test_streaming();
    dst_ready[2] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      src_vaild[2] = 1'b1;
      src_data[2]  = 9'(i);
      #1;
      n_checks++;
      if ({src_ready[2], dst_vaild[2], dst_data[2], occ[2]} !== {1'b1, 1'b1, 9'(i), 4'd0}) begin
        n_fail++;
        $display("FAIL stream beat %0d: src_ready=%b dst_vaild=%b dst_data=%0d occ=%0d, expected 1 1 %0d 0",
                 i, src_ready[2], dst_vaild[2], dst_data[2], occ[2], i);
      end
    end
    @(negedge clk);
    src_vaild[2] = 1'b0;
    #1;
    n_checks++;
    if ({dst_vaild[2], idle[2]} !== 2'b01) begin
      n_fail++;
      $display("FAIL stream_end: dst_vaild=%b idle=%b, expected 0 1", dst_vaild[2], idle[2]);
    end
    dst_ready[2] = 1'b0;
  endtask

  task automatic test_backpressure();
    dst_ready[2] = 1'b0;
    @(negedge clk); src_vaild[2] = 1'b1; src_data[2] = 9'h00A;
    #1;
    n_checks++;
    if ({dst_vaild[2], dst_data[2], src_ready[2]} !== {1'b1, 9'h00A, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_offer_a: dst_vaild=%b dst_data=%h src_ready=%b, expected 1 00a 1",
               dst_vaild[2], dst_data[2], src_ready[2]);
    end
    @(negedge clk); src_data[2] = 9'h00B;
    #1;
    n_checks++;
    if ({src_ready[2], dst_vaild[2], dst_data[2], occ[2]} !== {1'b0, 1'b1, 9'h00A, 4'd1}) begin
      n_fail++;
      $display("FAIL bp_full: src_ready=%b dst_vaild=%b dst_data=%h occ=%0d, expected 0 1 00a 1",
               src_ready[2], dst_vaild[2], dst_data[2], occ[2]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({src_ready[2], dst_vaild[2], dst_data[2]} !== {1'b0, 1'b1, 9'h00A}) begin
      n_fail++;
      $display("FAIL bp_stable: src_ready=%b dst_vaild=%b dst_data=%h, expected 0 1 00a",
               src_ready[2], dst_vaild[2], dst_data[2]);
    end
    @(negedge clk); dst_ready[2] = 1'b1;
    #1;
    $display("bp: dst beat %h", dst_data[2]);
    n_checks++;
    if ({src_ready[2], dst_data[2]} !== {1'b0, 9'h00A}) begin
      n_fail++;
      $display("FAIL bp_release_a: src_ready=%b dst_data=%h, expected 0 00a", src_ready[2], dst_data[2]);
    end
    @(negedge clk);
    #1;
    $display("bp: dst beat %h", dst_data[2]);
    n_checks++;
    if ({src_ready[2], dst_vaild[2], dst_data[2]} !== {1'b1, 1'b1, 9'h00B}) begin
      n_fail++;
      $display("FAIL bp_release_b: src_ready=%b dst_vaild=%b dst_data=%h, expected 1 1 00b",
               src_ready[2], dst_vaild[2], dst_data[2]);
    end
    @(negedge clk); src_vaild[2] = 1'b0;
    #1;
    n_checks++;
    if ({dst_vaild[2], idle[2]} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_drained: dst_vaild=%b idle=%b, expected 0 1", dst_vaild[2], idle[2]);
    end
    dst_ready[2] = 1'b0;
  endtask

  task automatic test_latency();
    int first;
    first = -1;
    dst_ready[1] = 1'b1;
    @(negedge clk); src_vaild[1] = 1'b1; src_data[1] = 9'h1FF;
    #1;
    n_checks++;
    if (src_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_accept: src_ready=%b, expected 1", src_ready[1]);
    end
    for (int c = 1; c <= 10 && first < 0; c++) begin
      @(negedge clk);
      src_vaild[1] = 1'b0;
      #1;
      if (c == 1) begin
        n_checks++;
        if (occ[1] !== 4'd1) begin
          n_fail++;
          $display("FAIL lat_occ: occ=%0d, expected 1", occ[1]);
        end
      end
      if (dst_vaild[1]) first = c;
    end
    n_checks++;
    if (first != 4 || dst_data[1] !== 9'h1FF) begin
      n_fail++;
      $display("FAIL lat_cycles: dst_vaild after %0d cycles data=%h, expected 4 cycles data 1ff",
               first, dst_data[1]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({dst_vaild[1], idle[1]} !== 2'b01) begin
      n_fail++;
      $display("FAIL lat_drained: dst_vaild=%b idle=%b, expected 0 1", dst_vaild[1], idle[1]);
    end
    dst_ready[1] = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    int nxt;
    int seen;
    acc = 0;
    nxt = 1;
    seen = 0;
    dst_ready[4] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      src_vaild[4] = (nxt <= 5);
      src_data[4]  = 9'(nxt);
      #1;
      if (src_vaild[4] && src_ready[4]) begin
        acc++;
        nxt++;
      end
    end
    n_checks++;
    if (acc != 4 || occ[4] !== 4'd4 || src_ready[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_cap: accepted=%0d occ=%0d src_ready=%b, expected 4 4 0",
               acc, occ[4], src_ready[4]);
    end
    for (int c = 0; c < 20 && seen < 5; c++) begin
      @(negedge clk);
      src_vaild[4] = (nxt <= 5);
      src_data[4]  = 9'(nxt);
      dst_ready[4] = 1'b1;
      #1;
      if (c == 0) begin
        n_checks++;
        if (src_ready[4] !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_ready_reg: src_ready=%b, expected 0", src_ready[4]);
        end
      end
      if (src_vaild[4] && src_ready[4]) nxt++;
      if (dst_vaild[4]) begin
        $display("fill: dst beat %0d", dst_data[4]);
        n_checks++;
        if (dst_data[4] !== 9'(seen + 1)) begin
          n_fail++;
          $display("FAIL fill_order: got %0d, expected %0d", dst_data[4], seen + 1);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 5) begin
      n_fail++;
      $display("FAIL fill_count: drained %0d beats, expected 5", seen);
    end
    @(negedge clk);
    src_vaild[4] = 1'b0;
    #1;
    n_checks++;
    if ({idle[4], occ[4]} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL fill_idle: idle=%b occ=%0d, expected 1 0", idle[4], occ[4]);
    end
    dst_ready[4] = 1'b0;
  endtask

  task automatic test_soak();
    for (int g = 0; g < N; g++) begin
      wr_p[g] = 0; rd_p[g] = 0; seq[g] = 0; took[g] = 1'b1; stall[g] = 1'b0; stall_data[g] = '0;
    end
    for (int cyc = 0; cyc < 2020; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (cyc >= 2000) begin
          src_vaild[g] = 1'b0;
          dst_ready[g] = 1'b1;
        end else begin
          if (!(src_vaild[g] && !took[g])) src_vaild[g] = ($urandom_range(0, 3) != 0);
          dst_ready[g] = ($urandom_range(0, 2) != 0);
        end
        src_data[g] = 9'(seq[g]);
      end
      #1;
      for (int g = 0; g < N; g++) begin
        n_checks++;
        if (occ[g] !== 4'(wr_p[g] - rd_p[g])) begin
          n_fail++;
          $display("FAIL soak_occ dut%0d cyc %0d: occ=%0d, expected %0d", g, cyc, occ[g], wr_p[g] - rd_p[g]);
        end
        if (stall[g]) begin
          n_checks++;
          if (dst_vaild[g] !== 1'b1 || dst_data[g] !== stall_data[g]) begin
            n_fail++;
            $display("FAIL soak_stable dut%0d cyc %0d: dst_vaild=%b dst_data=%0d, expected 1 %0d",
                     g, cyc, dst_vaild[g], dst_data[g], stall_data[g]);
          end
        end
        took[g] = src_vaild[g] && src_ready[g];
        if (took[g]) begin
          sb_mem[g][wr_p[g] % 16] = src_data[g];
          wr_p[g]++;
          seq[g]++;
        end
        if (dst_vaild[g] && dst_ready[g]) begin
          n_checks++;
          if (wr_p[g] == rd_p[g]) begin
            n_fail++;
            $display("FAIL soak_spurious dut%0d cyc %0d: got beat %0d, expected none", g, cyc, dst_data[g]);
          end else begin
            if (dst_data[g] !== sb_mem[g][rd_p[g] % 16]) begin
              n_fail++;
              $display("FAIL soak_data dut%0d cyc %0d: got %0d, expected %0d",
                       g, cyc, dst_data[g], sb_mem[g][rd_p[g] % 16]);
            end
            rd_p[g]++;
          end
        end
        stall[g]      = dst_vaild[g] && !dst_ready[g];
        stall_data[g] = dst_data[g];
      end
    end
    for (int g = 0; g < N; g++) begin
      n_checks++;
      if (wr_p[g] != rd_p[g] || idle[g] !== 1'b1 || wr_p[g] < 100) begin
        n_fail++;
        $display("FAIL soak_end dut%0d: sent %0d received %0d idle=%b, expected equal counts above 100 and idle 1",
                 g, wr_p[g], rd_p[g], idle[g]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    s_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mid_reset();
    test_streaming();
    test_backpressure();
    test_latency();
    test_fill();
    test_reset();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
